// File: rtl/io_port_unit_pkg.sv
// io_port_unit_pkg
//   Shared defaults for the buffered I/O port.
//   IO_WIDTH : datapath word width.
//   IO_DEPTH : entries per FIFO (power of 2, >= 2).
package io_port_unit_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 4;

endpackage

// File: rtl/io_port_unit_fifo.sv
// io_fifo
//   Synchronous circular FIFO with occupancy count.
//   Storage is cleared on reset so the head reads 0 until the first push.
// Ports
//   clock   : system clock, posedge
//   rst     : asynchronous active-low reset
//   push    : write wr_data (ignored when full)
//   pop     : advance head (ignored when empty)
//   wr_data : word to enqueue
//   head    : mem[rd_ptr], combinational
//   count   : occupancy, 0..DEPTH
//   full    : count == DEPTH
//   empty   : count == 0
module io_fifo
  import io_port_unit_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit
//   Buffered I/O port between the pipeline's mem stage and the outside world.
//   RX FIFO: filled by an external producer, drained by mem-stage reads.
//   TX FIFO: filled by mem-stage writes, drained by an external consumer.
// Ports
//   clock, rst                 : clock / async active-low reset
//   proc_rd_en, proc_rd_data   : mem-stage read request / registered result
//   proc_wr_en, proc_wr_data   : mem-stage write request / data
//   io_stall                   : request cannot complete this cycle
//   in_valid, in_ready, in_data    : external producer handshake
//   out_valid, out_ready, out_data : external consumer handshake
//   rx_count, tx_count         : FIFO occupancies
module io_port_unit
  import io_port_unit_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       proc_rd_en,
  output logic [WIDTH-1:0]           proc_rd_data,
  input  logic                       proc_wr_en,
  input  logic [WIDTH-1:0]           proc_wr_data,
  output logic                       io_stall,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic [$clog2(DEPTH+1)-1:0] tx_count
);

  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             rx_push, rx_pop, tx_push, tx_pop;
  logic [WIDTH-1:0] rx_head;

  // A stall on either side blocks both proc-side commits so the pair
  // retries together; external handshakes are unaffected.
  assign io_stall  = (proc_rd_en && rx_empty) || (proc_wr_en && tx_full);
  assign in_ready  = !rx_full;
  assign out_valid = !tx_empty;

  assign rx_push = in_valid && in_ready;
  assign rx_pop  = proc_rd_en && !io_stall;
  assign tx_push = proc_wr_en && !io_stall;
  assign tx_pop  = out_valid && out_ready;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rx_fifo (
    .clock   (clock),
    .rst     (rst),
    .push    (rx_push),
    .pop     (rx_pop),
    .wr_data (in_data),
    .head    (rx_head),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) tx_fifo (
    .clock   (clock),
    .rst     (rst),
    .push    (tx_push),
    .pop     (tx_pop),
    .wr_data (proc_wr_data),
    .head    (out_data),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // Read result: head captured on the popping edge, held until the next pop.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) proc_rd_data <= '0;
    else if (rx_pop) proc_rd_data <= rx_head;
  end

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit
//   Self-checking bench for io_port_unit (WIDTH=16, DEPTH=4): directed
//   scenarios plus randomized traffic, all compared against a queue model.
module tb_io_port_unit;

  localparam int W = 16;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         rst;
  logic         proc_rd_en, proc_wr_en, in_valid, out_ready;
  logic [W-1:0] proc_wr_data, in_data;
  logic [W-1:0] proc_rd_data, out_data;
  logic         io_stall, in_ready, out_valid;
  logic [2:0]   rx_count, tx_count;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] rxq[$];
  logic [W-1:0] txq[$];
  logic [W-1:0] exp_rd;

  io_port_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clock        (clock),
    .rst          (rst),
    .proc_rd_en   (proc_rd_en),
    .proc_rd_data (proc_rd_data),
    .proc_wr_en   (proc_wr_en),
    .proc_wr_data (proc_wr_data),
    .io_stall     (io_stall),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .rx_count     (rx_count),
    .tx_count     (tx_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_stall(input logic rd, input logic wr);
    return (rd && rxq.size() == 0) || (wr && txq.size() == D);
  endfunction

  // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input logic rd, input logic wr, input logic [W-1:0] wd,
                      input logic iv, input logic [W-1:0] id, input logic ordy);
    bit st;
    int rsz, tsz;
    proc_rd_en = rd; proc_wr_en = wr; proc_wr_data = wd;
    in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clock);
    st  = model_stall(rd, wr);
    rsz = rxq.size();
    tsz = txq.size();
    check("io_stall", io_stall, st);
    check("in_ready", in_ready, rsz != D);
    check("out_valid", out_valid, tsz != 0);
    check("rx_count", rx_count, rsz);
    check("tx_count", tx_count, tsz);
    check("proc_rd_data", proc_rd_data, exp_rd);
    if (tsz != 0) check("out_data", out_data, txq[0]);
    @(posedge clock);
    if (rd && !st) exp_rd = rxq.pop_front();
    if (iv && rsz < D) rxq.push_back(id);
    if (ordy && tsz > 0) void'(txq.pop_front());
    if (wr && !st) txq.push_back(wd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_data", proc_rd_data, 0);
    check("rst_io_stall", io_stall, 0);
  endtask

  initial begin
    rst = 1'b0;
    proc_rd_en = 0; proc_wr_en = 0; proc_wr_data = '0;
    in_valid = 0; in_data = '0; out_ready = 0;
    exp_rd = '0;
    #12;
    // Reset state
    check_reset_state();
    @(posedge clock); #1;
    rst = 1'b1;

    // Fill RX, fifth word refused, then four back-to-back reads
    step(0, 0, '0, 1, 16'h1111, 0);
    step(0, 0, '0, 1, 16'h2222, 0);
    step(0, 0, '0, 1, 16'h3333, 0);
    step(0, 0, '0, 1, 16'h4444, 0);
    check("rx_full_count", rx_count, 4);
    check("rx_full_ready", in_ready, 0);
    step(0, 0, '0, 1, 16'h5555, 0);
    check("rx_fifth_refused", rx_count, 4);
    step(1, 0, '0, 0, '0, 0);
    check("rd_1", proc_rd_data, 16'h1111);
    step(1, 0, '0, 0, '0, 0);
    check("rd_2", proc_rd_data, 16'h2222);
    step(1, 0, '0, 0, '0, 0);
    check("rd_3", proc_rd_data, 16'h3333);
    step(1, 0, '0, 0, '0, 0);
    check("rd_4", proc_rd_data, 16'h4444);

    // Read on empty RX stalls; producer push releases it
    step(1, 0, '0, 0, '0, 0);
    check("empty_rd_held", proc_rd_data, 16'h4444);
    step(1, 0, '0, 1, 16'hBEEF, 0);
    check("empty_rd_held2", proc_rd_data, 16'h4444);
    step(1, 0, '0, 0, '0, 0);
    check("beef_read", proc_rd_data, 16'hBEEF);

    // Fill TX, fifth write stalls, one consumer beat lets retry commit
    step(0, 1, 16'hA001, 0, '0, 0);
    step(0, 1, 16'hA002, 0, '0, 0);
    step(0, 1, 16'hA003, 0, '0, 0);
    step(0, 1, 16'hA004, 0, '0, 0);
    check("tx_full_count", tx_count, 4);
    step(0, 1, 16'hA005, 0, '0, 0);
    check("tx_fifth_stalled", tx_count, 4);
    step(0, 1, 16'hA005, 0, '0, 1);
    check("tx_head_after_pop", out_data, 16'hA002);
    step(0, 1, 16'hA005, 0, '0, 0);
    check("tx_retry_count", tx_count, 4);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, '0, 1);
    check("tx_drained", out_valid, 0);

    // Simultaneous RX push/pop at count 2 and at full
    step(0, 0, '0, 1, 16'hC001, 0);
    step(0, 0, '0, 1, 16'hC002, 0);
    step(1, 0, '0, 1, 16'hC003, 0);
    check("rx_pp_count", rx_count, 2);
    check("rx_pp_data", proc_rd_data, 16'hC001);
    step(0, 0, '0, 1, 16'hC004, 0);
    step(0, 0, '0, 1, 16'hC005, 0);
    step(1, 0, '0, 1, 16'hC006, 0);
    check("rx_full_pp_count", rx_count, 3);
    check("rx_full_pp_data", proc_rd_data, 16'hC002);

    // Mid-operation reset with RX=3, TX=2 buffered
    step(0, 1, 16'hD001, 0, '0, 0);
    step(0, 1, 16'hD002, 0, '0, 0);
    check("pre_rst_rx", rx_count, 3);
    check("pre_rst_tx", tx_count, 2);
    #2 rst = 1'b0;
    #1;
    check_reset_state();
    rxq.delete(); txq.delete(); exp_rd = '0;
    @(posedge clock); #1;
    rst = 1'b1;
    step(0, 1, 16'hE001, 1, 16'hE002, 0);
    step(1, 0, '0, 0, '0, 1);
    check("post_rst_rd", proc_rd_data, 16'hE002);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40, W'($urandom),
           $urandom_range(0, 99) < 45, W'($urandom), $urandom_range(0, 99) < 45);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
